// File: rtl/bus_capture_fifo.sv
// Captures a byte from a shared bus on each falling edge of the sender strobe
// into a 4-deep first-word-fall-through FIFO with a sticky overflow flag.
module bus_capture_fifo (
    input  logic       sysclk,
    input  logic       sys_rst,
    input  logic [7:0] BUS_D,
    input  logic       STB_n,
    input  logic       READY,
    input  logic       CLR_OVF,
    output logic [7:0] DOUT,
    output logic       VALID,
    output logic       FULL,
    output logic       OVF,
    output logic [2:0] COUNT
);

    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       stb_q;
    logic       ovf;

    logic capture;
    logic pop;
    logic push;
    logic drop;

    // Handshake: a word leaves the FIFO in any cycle where VALID and READY are
    // both high at the rising edge; READY with VALID low has no effect.
    assign VALID   = (count != 3'd0);
    assign FULL    = (count == 3'd4);
    assign capture = stb_q && !STB_n;
    assign pop     = VALID && READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = capture && (!FULL || pop);
    assign drop    = capture && FULL && !pop;

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            stb_q  <= 1'b0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ovf    <= 1'b0;
        end else begin
            stb_q <= STB_n;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (CLR_OVF) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset; the pointers and count decide what is visible.
    always_ff @(posedge sysclk) begin
        if (!sys_rst && push) begin
            mem[wr_ptr] <= BUS_D;
        end
    end

    assign DOUT  = VALID ? mem[rd_ptr] : 8'h00;
    assign OVF   = ovf;
    assign COUNT = count;

endmodule

// File: tb/tb_bus_capture_fifo.sv
// Bench for bus_capture_fifo: a cycle-stepped driver with a reference
// queue of expected words and flag model checked after every clock edge.
module tb_bus_capture_fifo;

    logic       sysclk;
    logic       sys_rst;
    logic [7:0] BUS_D;
    logic       STB_n;
    logic       READY;
    logic       CLR_OVF;
    logic [7:0] DOUT;
    logic       VALID;
    logic       FULL;
    logic       OVF;
    logic [2:0] COUNT;

    logic [7:0] exp_q[$];
    logic       m_stb_q;
    logic       m_ovf;
    int         n_checks;
    int         n_fail;

    bus_capture_fifo dut (
        .sysclk (sysclk),
        .sys_rst(sys_rst),
        .BUS_D  (BUS_D),
        .STB_n  (STB_n),
        .READY  (READY),
        .CLR_OVF(CLR_OVF),
        .DOUT   (DOUT),
        .VALID  (VALID),
        .FULL   (FULL),
        .OVF    (OVF),
        .COUNT  (COUNT)
    );

    // clock / reset
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = exp_q.size();
        check_eq({tag, ".count"}, 32'(COUNT), 32'(sz));
        check_eq({tag, ".valid"}, 32'(VALID), 32'(sz != 0));
        check_eq({tag, ".full"},  32'(FULL),  32'(sz == 4));
        check_eq({tag, ".ovf"},   32'(OVF),   32'(m_ovf));
        if (sz != 0) check_eq({tag, ".dout"}, 32'(DOUT), 32'(exp_q[0]));
        else         check_eq({tag, ".dout_idle"}, 32'(DOUT), 32'h0);
    endtask

    // One clock: apply inputs, update the reference model, check after the edge.
    task automatic step(input string tag, input logic stb, input logic [7:0] d,
                        input logic rdy, input logic clr);
        logic cap;
        logic pop;
        logic was_full;
        STB_n   = stb;
        BUS_D   = d;
        READY   = rdy;
        CLR_OVF = clr;
        cap      = m_stb_q && !stb;
        pop      = (exp_q.size() != 0) && rdy;
        was_full = (exp_q.size() == 4);
        if (pop) begin
            check_eq({tag, ".pop_data"}, 32'(DOUT), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (cap) begin
            if (!was_full || pop) exp_q.push_back(d);
            else                  m_ovf = 1'b1;
        end
        if (clr && !(cap && was_full && !pop)) m_ovf = 1'b0;
        m_stb_q = stb;
        @(posedge sysclk);
        #1;
        check_outputs(tag);
    endtask

    task automatic strobe(input string tag, input logic [7:0] d, input logic rdy);
        step(tag, 1'b0, d, rdy, 1'b0);
        step(tag, 1'b1, 8'h00, rdy, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5; i++) step(tag, 1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    // Reset is held with READY and CLR_OVF asserted to show it dominates.
    task automatic do_reset(input logic stb);
        sys_rst = 1'b1;
        STB_n   = stb;
        READY   = 1'b1;
        CLR_OVF = 1'b1;
        exp_q.delete();
        m_ovf   = 1'b0;
        m_stb_q = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge sysclk);
            #1;
            check_outputs("reset");
        end
        sys_rst = 1'b0;
        READY   = 1'b0;
        CLR_OVF = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sys_rst  = 1'b1;
        BUS_D    = 8'h00;
        STB_n    = 1'b1;
        READY    = 1'b0;
        CLR_OVF  = 1'b0;
        m_stb_q  = 1'b0;
        m_ovf    = 1'b0;
        @(posedge sysclk);
        #1;
        do_reset(1'b1);

        // single capture, one-cycle latency
        step("idle", 1'b1, 8'h00, 1'b0, 1'b0);
        step("a5_cap", 1'b0, 8'hA5, 1'b0, 1'b0);
        check_eq("a5_dout", 32'(DOUT), 32'hA5);
        check_eq("a5_count", 32'(COUNT), 32'd1);
        step("a5_hold", 1'b1, 8'h00, 1'b0, 1'b0);
        drain("a5_drain");

        // fill to four, then read back in order
        strobe("f11", 8'h11, 1'b0);
        strobe("f22", 8'h22, 1'b0);
        strobe("f33", 8'h33, 1'b0);
        strobe("f44", 8'h44, 1'b0);
        check_eq("fill_full", 32'(FULL), 32'd1);
        for (int i = 0; i < 4; i++) step("read4", 1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("read4_valid", 32'(VALID), 32'd0);
        check_eq("read4_dout", 32'(DOUT), 32'h00);

        // overflow drop, then clear
        strobe("o1", 8'h01, 1'b0);
        strobe("o2", 8'h02, 1'b0);
        strobe("o3", 8'h03, 1'b0);
        strobe("o4", 8'h04, 1'b0);
        strobe("o55", 8'h55, 1'b0);
        check_eq("ovf_set", 32'(OVF), 32'd1);
        step("ovf_hold", 1'b1, 8'h00, 1'b0, 1'b0);
        step("ovf_clr", 1'b1, 8'h00, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(OVF), 32'd0);

        // drop and clear in the same cycle: set wins
        step("sw_pre", 1'b0, 8'h5A, 1'b0, 1'b1);
        check_eq("set_wins", 32'(OVF), 32'd1);
        step("sw_hi", 1'b1, 8'h00, 1'b0, 1'b0);
        step("sw_clr", 1'b1, 8'h00, 1'b0, 1'b1);

        // full with simultaneous pop accepts the new word
        step("fp66", 1'b0, 8'h66, 1'b1, 1'b0);
        check_eq("fp66_count", 32'(COUNT), 32'd4);
        check_eq("fp66_ovf", 32'(OVF), 32'd0);
        step("fp66_hi", 1'b1, 8'h00, 1'b0, 1'b0);
        drain("fp_drain");

        // capture while empty with READY high: push only
        step("er_pre", 1'b1, 8'h00, 1'b1, 1'b0);
        step("er_cap", 1'b0, 8'h3C, 1'b1, 1'b0);
        check_eq("er_count", 32'(COUNT), 32'd1);
        step("er_pop", 1'b1, 8'h00, 1'b1, 1'b0);

        // long low strobe yields one capture
        for (int i = 0; i < 10; i++) step("long", 1'b0, 8'h77, 1'b0, 1'b0);
        check_eq("long_count", 32'(COUNT), 32'd1);
        step("long_hi", 1'b1, 8'h00, 1'b0, 1'b0);

        // reset mid-operation discards words; strobe low across reset must not capture
        strobe("pre_rst", 8'h99, 1'b0);
        STB_n = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step("rst_low", 1'b0, 8'hEE, 1'b0, 1'b0);
        check_eq("rst_low_count", 32'(COUNT), 32'd0);
        step("rst_hi", 1'b1, 8'h00, 1'b0, 1'b0);
        step("rst_cap", 1'b0, 8'hBE, 1'b0, 1'b0);
        check_eq("rst_cap_count", 32'(COUNT), 32'd1);
        step("rst_cap_hi", 1'b1, 8'h00, 1'b0, 1'b0);
        drain("rst_drain");

        // interleaved push/pop so both pointers wrap
        for (int i = 0; i < 6; i++) begin
            strobe("wrap_push", 8'($urandom_range(0, 255)), 1'b0);
            step("wrap_pop", 1'b1, 8'h00, 1'b1, 1'b0);
        end

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
